mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS-subset core. It sequences the shared execute stage, register file and unified memory through an IDLE/FETCH/DECODE/EXEC/MEM/WB state machine. It also generates the per-state control strobes and the 2-bit ALU op for the ALU controller, and handshakes with a variable-latency memory. It also provides a retired-instruction counter and halt/illegal-instruction status.

---
 rtl/mc_pkg.sv | 31 +++
 rtl/mc_decode.sv | 27 ++
 rtl/mc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: controller states,
// opcode encodings and ALU/PC select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } ctrl_state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier; exactly one output is high for any opcode.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_r,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_addi,
    output logic       is_beq,
    output logic       is_j,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        is_r    = (opcode == OP_R);
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
        is_addi = (opcode == OP_ADDI);
        is_beq  = (opcode == OP_BEQ);
        is_j    = (opcode == OP_J);
        is_halt = (opcode == OP_HALT);
        is_illegal = !(is_r || is_lw || is_sw || is_addi || is_beq || is_j || is_halt);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/write-back,
// drives per-state strobes, counts retired instructions and tracks halt status.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  op,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count
);

    ctrl_state_t state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [31:0] count_q, count_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;
    logic        retire;

    logic [5:0] opc_sel;
    logic is_r, is_lw, is_sw, is_addi, is_beq, is_j, is_halt, is_illegal;

    // DECODE classifies the live IR field; later states use the latched copy.
    assign opc_sel = (state_q == StDecode) ? opcode : opcode_q;

    mc_decode u_decode (
        .opcode     (opc_sel),
        .is_r       (is_r),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_addi    (is_addi),
        .is_beq     (is_beq),
        .is_j       (is_j),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        count_d    = count_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_INC;
        op         = ALUOP_ADD;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_INC;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                opcode_d = opcode;
                if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    retire   = 1'b1;
                end else if (is_halt) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else if (is_illegal) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_r) begin
                    op      = ALUOP_FUNCT;
                    state_d = StWb;
                end else if (is_beq) begin
                    op       = ALUOP_SUB;
                    pc_src   = PC_SRC_BRANCH;
                    pc_write = zero;
                    retire   = 1'b1;
                end else begin
                    op      = ALUOP_ADD;
                    alu_src = 1'b1;
                    state_d = is_addi ? StWb : StMem;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = is_sw;
                if (mem_ack) begin
                    if (is_sw) retire = 1'b1;
                    else       state_d = StWb;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                retire     = 1'b1;
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase

        if (retire) begin
            count_d = count_q + 32'd1;
            state_d = run ? StFetch : StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            opcode_q  <= 6'd0;
            count_q   <= 32'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle strobe vectors against hand-computed values.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src, op;
    logic        alu_src, reg_dst, reg_write, mem_to_reg;
    logic        halted, illegal;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_pass   = 0;

    // {req,we,i_or_d}_{ir_write,pc_write}_{pc_src}_{op}_{alu_src,reg_dst,reg_write,mem_to_reg}
    logic [12:0] sb;
    assign sb = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, op,
                 alu_src, reg_dst, reg_write, mem_to_reg};

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .op          (op),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One cycle: drive inputs at the falling edge, check strobes 1ns later.
    task automatic cyc(input string tag, input logic r, input logic a, input logic z,
                       input logic [5:0] opc, input logic [12:0] exp);
        run = r; mem_ack = a; zero = z; opcode = opc;
        #1;
        check(tag, {19'd0, sb}, {19'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ack = 1'b0;
        #1;
        check("rst_sb", {19'd0, sb}, 32'd0);
        check("rst_cnt", instr_count, 32'd0);
        check("rst_flags", {30'd0, halted, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type, zero-wait fetch
        cyc("idle",      1, 0, 0, 6'h00, 13'b000_00_00_00_0000);
        cyc("r_fetch",   1, 1, 0, 6'h00, 13'b100_11_00_00_0000);
        cyc("r_decode",  1, 0, 0, 6'h00, 13'b000_00_00_00_0000);
        cyc("r_exec",    1, 0, 0, 6'h3A, 13'b000_00_00_10_0000);
        cyc("r_wb",      1, 0, 0, 6'h3A, 13'b000_00_00_00_0110);
        #1 check("r_cnt", instr_count, 32'd1);
        #0;

        // LW, 3 wait cycles in FETCH and MEM (11 cycles)
        cyc("lw_fw0",    1, 0, 0, 6'h23, 13'b100_00_00_00_0000);
        cyc("lw_fw1",    1, 0, 0, 6'h23, 13'b100_00_00_00_0000);
        cyc("lw_fw2",    1, 0, 0, 6'h23, 13'b100_00_00_00_0000);
        cyc("lw_fack",   1, 1, 0, 6'h23, 13'b100_11_00_00_0000);
        cyc("lw_dec",    1, 1, 0, 6'h23, 13'b000_00_00_00_0000);
        cyc("lw_exec",   1, 1, 0, 6'h00, 13'b000_00_00_00_1000);
        cyc("lw_mw0",    1, 0, 0, 6'h00, 13'b101_00_00_00_0000);
        cyc("lw_mw1",    1, 0, 0, 6'h00, 13'b101_00_00_00_0000);
        cyc("lw_mw2",    1, 0, 0, 6'h00, 13'b101_00_00_00_0000);
        cyc("lw_mack",   1, 1, 0, 6'h00, 13'b101_00_00_00_0000);
        cyc("lw_wb",     1, 0, 0, 6'h00, 13'b000_00_00_00_0011);
        check("lw_cnt", instr_count, 32'd2);

        // BEQ taken then not taken
        cyc("beq1_f",    1, 1, 1, 6'h04, 13'b100_11_00_00_0000);
        cyc("beq1_d",    1, 0, 1, 6'h04, 13'b000_00_00_00_0000);
        cyc("beq1_ex",   1, 0, 1, 6'h3A, 13'b000_01_01_01_0000);
        cyc("beq0_f",    1, 1, 0, 6'h04, 13'b100_11_00_00_0000);
        cyc("beq0_d",    1, 0, 0, 6'h04, 13'b000_00_00_00_0000);
        cyc("beq0_ex",   1, 0, 0, 6'h3A, 13'b000_00_01_01_0000);
        check("beq_cnt", instr_count, 32'd4);

        // J
        cyc("j_f",       1, 1, 0, 6'h02, 13'b100_11_00_00_0000);
        cyc("j_d",       1, 0, 0, 6'h02, 13'b000_01_10_00_0000);
        check("j_cnt", instr_count, 32'd5);

        // ADDI
        cyc("addi_f",    1, 1, 0, 6'h08, 13'b100_11_00_00_0000);
        cyc("addi_d",    1, 0, 0, 6'h08, 13'b000_00_00_00_0000);
        cyc("addi_ex",   1, 0, 0, 6'h08, 13'b000_00_00_00_1000);
        cyc("addi_wb",   1, 0, 0, 6'h08, 13'b000_00_00_00_0010);
        check("addi_cnt", instr_count, 32'd6);

        // SW with run dropped during MEM
        cyc("sw_f",      1, 1, 0, 6'h2B, 13'b100_11_00_00_0000);
        cyc("sw_d",      1, 0, 0, 6'h2B, 13'b000_00_00_00_0000);
        cyc("sw_ex",     1, 0, 0, 6'h2B, 13'b000_00_00_00_1000);
        cyc("sw_mw",     0, 0, 0, 6'h2B, 13'b111_00_00_00_0000);
        cyc("sw_mack",   0, 1, 0, 6'h2B, 13'b111_00_00_00_0000);
        check("sw_cnt", instr_count, 32'd7);
        cyc("sw_idle0",  0, 1, 0, 6'h2B, 13'b000_00_00_00_0000);
        cyc("sw_idle1",  0, 0, 0, 6'h2B, 13'b000_00_00_00_0000);
        check("sw_cnt2", instr_count, 32'd7);

        // Reset during the FETCH wait
        cyc("rs_idle",   1, 0, 0, 6'h00, 13'b000_00_00_00_0000);
        run = 1'b1; mem_ack = 1'b0;
        #1 check("rs_req", {31'd0, mem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("rs_sb", {19'd0, sb}, 32'd0);
        check("rs_cnt", instr_count, 32'd0);
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        #1 check("rs_rel_sb", {19'd0, sb}, 32'd0);
        @(negedge clk);

        // Counter wrap
        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        #1 check("wrap_pre", instr_count, 32'hFFFF_FFFF);
        @(negedge clk);
        cyc("wrap_idle", 1, 0, 0, 6'h02, 13'b000_00_00_00_0000);
        cyc("wrap_f",    1, 1, 0, 6'h02, 13'b100_11_00_00_0000);
        cyc("wrap_d",    1, 0, 0, 6'h02, 13'b000_01_10_00_0000);
        check("wrap_cnt", instr_count, 32'd0);

        // Illegal opcode: halts, ignores run and ack
        cyc("ill_f",     1, 1, 0, 6'h3A, 13'b100_11_00_00_0000);
        cyc("ill_d",     1, 0, 0, 6'h3A, 13'b000_00_00_00_0000);
        cyc("ill_h0",    1, 1, 0, 6'h00, 13'b000_00_00_00_0000);
        cyc("ill_h1",    1, 1, 0, 6'h23, 13'b000_00_00_00_0000);
        check("ill_flags", {30'd0, halted, illegal}, 32'd3);
        check("ill_cnt", instr_count, 32'd0);
        rst_n = 1'b0;
        #1 check("ill_rst", {30'd0, halted, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // HALT opcode
        cyc("h_idle",    1, 0, 0, 6'h3F, 13'b000_00_00_00_0000);
        cyc("h_f",       1, 1, 0, 6'h3F, 13'b100_11_00_00_0000);
        cyc("h_d",       1, 0, 0, 6'h3F, 13'b000_00_00_00_0000);
        cyc("h_h",       1, 1, 0, 6'h00, 13'b000_00_00_00_0000);
        check("h_flags", {30'd0, halted, illegal}, 32'd2);
        check("h_cnt", instr_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
